// File: rtl/fetch_if.sv
// Bundle of fetch-stage signals: hazard/redirect controls in, IM address and D-stage outputs out.
interface fetch_if;
  logic        stall;
  logic        exc_flush;
  logic        eret_d;
  logic [31:0] epc;
  logic        br_taken_d;
  logic [31:0] br_target_d;
  logic        is_br_d;
  logic [31:0] imem_rdata;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [4:0]  excD;
  logic        bdD;

  modport master (
    output stall, exc_flush, eret_d, epc, br_taken_d, br_target_d, is_br_d, imem_rdata,
    input  pcF, instrD, pcD, excD, bdD
  );

  modport slave (
    input  stall, exc_flush, eret_d, epc, br_taken_d, br_target_d, is_br_d, imem_rdata,
    output pcF, instrD, pcD, excD, bdD
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC priority select, AdEL detection on the fetch
// address and the F/D pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave fif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;

  logic        adel_f;
  logic [31:0] word_f;
  logic [4:0]  exc_f;

  always_comb begin
    // F stage: a faulting fetch becomes a nop carrying AdEL down the pipe
    adel_f = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    word_f = adel_f ? 32'h0 : fif.imem_rdata;
    exc_f  = adel_f ? 5'd4 : 5'd0;

    pc_d    = pc_q + 32'd4;
    instr_d = word_f;
    pcd_d   = pc_q;
    exc_d   = exc_f;
    bd_d    = fif.is_br_d;

    if (fif.exc_flush) begin
      pc_d    = EXC_VECTOR;
      instr_d = '0;
      pcd_d   = '0;
      exc_d   = '0;
      bd_d    = 1'b0;
    end else if (fif.stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pcd_d   = pcd_q;
      exc_d   = exc_q;
      bd_d    = bd_q;
    end else if (fif.eret_d) begin
      // eret has no delay slot: the word fetched behind it is squashed
      pc_d    = fif.epc;
      instr_d = '0;
      pcd_d   = '0;
      exc_d   = '0;
      bd_d    = 1'b0;
    end else if (fif.br_taken_d) begin
      pc_d = fif.br_target_d;
    end
  end

  // F/D boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_RESET;
      instr_q <= '0;
      pcd_q   <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign fif.pcF    = pc_q;
  assign fif.instrD = instr_q;
  assign fif.pcD    = pcd_q;
  assign fif.excD   = exc_q;
  assign fif.bdD    = bd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected post-edge state,
// which is popped and compared one time unit after the rising edge.
module tb_fetch_stage;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic rst;

  fetch_if fif ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0111_0001;
  endfunction

  assign fif.imem_rdata = imem_word(fif.pcF);

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_instr, m_pcd;
  logic [4:0]  m_exc;
  logic        m_bd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic fl, input logic er,
                     input logic [31:0] ep, input logic bt, input logic [31:0] tg,
                     input logic ib, input string tag);
    exp_t e;
    logic adel;
    rst             = r;
    fif.stall       = st;
    fif.exc_flush   = fl;
    fif.eret_d      = er;
    fif.epc         = ep;
    fif.br_taken_d  = bt;
    fif.br_target_d = tg;
    fif.is_br_d     = ib;

    adel = (m_pc[1:0] != 2'b00) || (m_pc < IM_LO) || (m_pc > IM_HI);
    if (r) begin
      m_pc = PC_RESET; m_instr = '0; m_pcd = '0; m_exc = '0; m_bd = 1'b0;
    end else if (fl) begin
      m_pc = EXC_VECTOR; m_instr = '0; m_pcd = '0; m_exc = '0; m_bd = 1'b0;
    end else if (st) begin
      // hold everything
    end else if (er) begin
      m_pc = ep; m_instr = '0; m_pcd = '0; m_exc = '0; m_bd = 1'b0;
    end else begin
      m_instr = adel ? 32'h0 : imem_word(m_pc);
      m_pcd   = m_pc;
      m_exc   = adel ? 5'd4 : 5'd0;
      m_bd    = ib;
      m_pc    = bt ? tg : m_pc + 32'd4;
    end
    e.pcf = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.exc = m_exc; e.bd = m_bd;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pcF"},    fif.pcF,          e.pcf);
    chk({tag, ".instrD"}, fif.instrD,       e.instr);
    chk({tag, ".pcD"},    fif.pcD,          e.pcd);
    chk({tag, ".excD"},   {27'h0, fif.excD}, {27'h0, e.exc});
    chk({tag, ".bdD"},    {31'h0, fif.bdD},  {31'h0, e.bd});
  endtask

  task automatic nrm(input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, tag);
  endtask

  task automatic br(input logic [31:0] tg, input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, tg, 1'b1, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tgts [8];
    m_pc = 'x; m_instr = 'x; m_pcd = 'x; m_exc = 'x; m_bd = 1'bx;
    tgts[0] = 32'h0000_3100; tgts[1] = 32'h0000_3102; tgts[2] = 32'h0000_7000;
    tgts[3] = 32'h0000_6FFC; tgts[4] = 32'h0000_2FFC; tgts[5] = 32'h0000_3FF0;
    tgts[6] = 32'hFFFF_FFFC; tgts[7] = 32'h0000_5001;

    // reset for two cycles
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rst0");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rst1");
    chk("rst_pcF_const", fif.pcF, 32'h0000_3000);
    chk("rst_instrD_const", fif.instrD, 32'h0);

    nrm("run0");
    chk("run0_pcD_const", fif.pcD, 32'h0000_3000);
    chk("run0_pcF_const", fif.pcF, 32'h0000_3004);
    nrm("run1");
    nrm("run2");
    chk("run2_pcF_const", fif.pcF, 32'h0000_300C);

    // stall three cycles at 300C
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3200, 1'b1, "stall");
    chk("stall_pcF_const", fif.pcF, 32'h0000_300C);
    nrm("unstall");
    chk("unstall_pcD_const", fif.pcD, 32'h0000_300C);
    chk("unstall_pcF_const", fif.pcF, 32'h0000_3010);

    // branch with delay slot, then fall-through
    br(32'h0000_3100, "br");
    chk("br_bd_const", {31'h0, fif.bdD}, 32'h1);
    chk("br_pcF_const", fif.pcF, 32'h0000_3100);
    nrm("after_br");
    chk("after_br_pcD_const", fif.pcD, 32'h0000_3100);
    chk("after_br_bd_const", {31'h0, fif.bdD}, 32'h0);

    // misaligned target
    br(32'h0000_3102, "br_mis");
    nrm("mis_fetch");
    chk("mis_exc_const", {27'h0, fif.excD}, 32'h4);
    chk("mis_pcD_const", fif.pcD, 32'h0000_3102);
    chk("mis_instr_const", fif.instrD, 32'h0);

    // out-of-range target, and a faulting delay slot
    br(32'h0000_7000, "br_oor");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "oor_ds");
    chk("oor_exc_const", {27'h0, fif.excD}, 32'h4);
    chk("oor_bd_const", {31'h0, fif.bdD}, 32'h1);

    // upper boundary: 6FFC legal, then +4 faults
    br(32'h0000_6FFC, "br_hi");
    nrm("hi_ok");
    chk("hi_exc_const", {27'h0, fif.excD}, 32'h0);
    nrm("hi_over");
    chk("hi_over_exc_const", {27'h0, fif.excD}, 32'h4);

    // below IM_LO and wrap at 2^32
    br(32'h0000_2FFC, "br_lo");
    nrm("lo_fetch");
    br(32'hFFFF_FFFC, "br_wrap");
    nrm("wrap0");
    nrm("wrap1");
    chk("wrap_pcD_const", fif.pcD, 32'h0);
    chk("wrap_exc_const", {27'h0, fif.excD}, 32'h4);

    // exception flush beats stall and branch
    br(32'h0000_3040, "pre_flush");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3100, 1'b1, "flush");
    chk("flush_pcF_const", fif.pcF, 32'h0000_4180);
    nrm("post_flush");

    // eret: plain, then held by stall
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3024, 1'b0, 32'h0, 1'b0, "eret");
    chk("eret_pcF_const", fif.pcF, 32'h0000_3024);
    chk("eret_pcD_const", fif.pcD, 32'h0);
    nrm("post_eret");
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3060, 1'b0, 32'h0, 1'b0, "eret_st");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3060, 1'b0, 32'h0, 1'b0, "eret_go");
    chk("eret_go_pcF_const", fif.pcF, 32'h0000_3060);

    // reset wins over stall and flush
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rst_mid");
    chk("rst_mid_pcF_const", fif.pcF, 32'h0000_3000);

    // random mix
    for (int i = 0; i < 60; i++) begin
      logic st, fl, er, bt;
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 12) == 0);
      er = ($urandom_range(0, 8) == 0);
      bt = er ? 1'b0 : ($urandom_range(0, 3) == 0);
      cyc(1'b0, st, fl, er, tgts[$urandom_range(0, 7)], bt, tgts[$urandom_range(0, 7)],
          1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the P7 exception-capable pipeline: PC register, next-PC selection, fetch-address exception detection, and the F/D pipeline register.
- Drives the instruction-memory address.
- Produces instrD, pcD, excD and bdD. These are consumed by D-stage decode and by the D/E instruction register downstream.
- Honours hazard stalls, branch/jump redirects, eret returns and the global exception flush.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception/interrupt flush.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hazard-unit stall; freezes PC and the F/D register.
- exc_flush  input  1  CP0 exception/interrupt taken; redirects to EXC_VECTOR and clears F/D (same cycle as DEMWclr downstream).
- eret_d  input  1  eret decoded in D.
- epc  input  32  CP0 EPC value.
- br_taken_d  input  1  D-stage branch/jump redirect.
- br_target_d  input  32  redirect target.
- is_br_d  input  1  instruction now in D is a branch/jump; marks the next fetch as a delay slot.
- imem_rdata  input  32  instruction word at pcF (combinational IM read).
- pcF  output  32  current fetch address to IM.
- instrD  output  32  instruction in D.
- pcD  output  32  PC of instrD.
- excD  output  5  exception code carried with instrD (0 = none, 4 = AdEL).
- bdD  output  1  instrD is in a branch delay slot.

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: PC = PC_RESET; instrD = 0, pcD = 0, excD = 0, bdD = 0.
- pcF is the PC register, driven combinationally to IM.
- Fetch-exception detection (combinational on pcF):
  - adel_f = (pcF[1:0] != 0) OR (pcF < IM_LO) OR (pcF > IM_HI), with unsigned compares.
  - When adel_f = 1, the instruction word latched into D is 32'h0 (nop) and excF = 5'd4; otherwise the word is imem_rdata and excF = 0.
- Next PC, evaluated at each rising edge in strict priority:
  1. rst -> PC_RESET.
  2. exc_flush -> EXC_VECTOR.
  3. stall -> hold PC.
  4. eret_d -> epc.
  5. br_taken_d -> br_target_d.
  6. otherwise PC + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0, which then raises AdEL.
- F/D register update, same priority order:
  - rst or exc_flush: instrD/pcD/excD/bdD <- 0.
  - stall: hold all four.
  - eret_d (not stalled): insert a bubble (all <- 0). eret has no delay slot, so the word fetched behind it is discarded.
  - otherwise: instrD <- fetched word (or nop on AdEL), pcD <- pcF, excD <- excF, bdD <- is_br_d.
  - br_taken_d does NOT flush F/D; the delay-slot instruction proceeds with bdD = 1.
- Latency: one cycle from pcF to the D-stage outputs.
- Simultaneous events:
  - exc_flush overrides stall, eret_d and br_taken_d.
  - stall overrides eret_d and br_taken_d; the hazard unit re-presents both in the unstalled cycle.
  - eret_d together with br_taken_d is illegal; eret_d wins.
- A faulting fetch (AdEL) still enters D with pcD = faulting address. This lets CP0 record EPC/BadVAddr at M.
- bdD accompanies an AdEL bubble too: a faulting delay slot sets bdD = 1.
- rst asserted mid-stall or mid-flush: reset values win on that edge.
- No combinational path from any input to instrD/pcD/excD/bdD.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with no stall or branch -> pcF = 3000, 3004, 3008; instrD follows imem_rdata one cycle later; pcD = 3000 on the first post-reset edge.
- Stall: stall=1 for 3 cycles at pcF=300C -> pcF stays 300C and instrD/pcD hold; stall=0 -> pcF = 3010, pcD = 300C.
- Branch + delay slot: D holds a beq (is_br_d=1, br_taken_d=1, target 3100) while pcF=3008 -> next pcD = 3008 with bdD=1, pcF = 3100; the following pcD = 3100 with bdD=0.
- Misaligned fetch: br_target_d=3102 -> next edge instrD=0, excD=4, pcD=3102; an out-of-range target 7000 gives the same excD=4.
- Exception flush: exc_flush=1 together with stall=1 and br_taken_d=1 -> pcF = 4180, instrD/pcD/excD/bdD = 0.
- eret: eret_d=1 with epc=3024 -> pcF = 3024 and D becomes a bubble (instrD=0, pcD=0); with stall=1 also asserted -> PC and D hold until stall drops, then the redirect occurs.
